// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access stage of the five-stage RV32I pipeline.
// Issues word loads/stores on the data-memory bus, stalls the pipeline while
// an access is outstanding and registers the MEM/WB write-back results.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   -> misaligned accesses are suppressed and flagged on mem_misaligned
//   undefined -> no check, dmem_addr[1:0] forced to 0, no mem_misaligned port
//
// Bus handshake: dmem_req is the request valid, dmem_ready is the accept.
// A request is transferred in a cycle where dmem_req=1 and dmem_ready=1; while
// dmem_req=1 and dmem_ready=0 the request (we/addr/wdata) is held stable.
// dmem_ready is ignored when dmem_req=0. For a load, dmem_rvalid returns the
// data no earlier than the cycle after acceptance and is ignored in any cycle
// the FSM is not waiting for it.
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_mem_memread,
  input  logic        ex_mem_memwrite,
  input  logic        ex_mem_memtoreg,
  input  logic        ex_mem_regwrite,
  input  logic        ex_mem_jal,
  input  logic        ex_mem_jalr,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_data_read2,
  input  logic [4:0]  ex_mem_reg_dest,
  input  logic [31:0] ex_mem_link_address_reg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_wb_regwrite,
  output logic [4:0]  mem_wb_reg_dest,
  output logic [31:0] mem_wb_wb_data,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        mem_misaligned,
`endif
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t state, state_next;

  logic        access;
  logic        is_store;
  logic        fault;
  logic        complete;
  logic        req_raw;
  logic [31:0] wb_sel;

  assign access   = ex_mem_memread | ex_mem_memwrite;
  // memread and memwrite together is illegal; the write wins.
  assign is_store = ex_mem_memwrite;

`ifdef MEM_ALIGN_CHECK_EN
  // A misaligned access is only recognised when it starts in IDLE.
  assign fault     = (state == IDLE) & access & (ex_mem_alu_result[1:0] != 2'b00);
  assign dmem_addr = ex_mem_alu_result;
`else
  assign fault     = 1'b0;
  assign dmem_addr = {ex_mem_alu_result[31:2], 2'b00};
`endif

  assign dmem_we    = ex_mem_memwrite;
  assign dmem_wdata = ex_mem_data_read2;
  assign dmem_req   = req_raw & ~reset;
  assign mem_stall  = ~complete;
  assign state_dbg  = state;

  // Next-state, request and completion decode for the current EX/MEM instruction.
  always_comb begin
    state_next = state;
    complete   = 1'b0;
    req_raw    = 1'b0;
    case (state)
      IDLE: begin
        if (!access || fault) begin
          complete = 1'b1;
        end else begin
          req_raw = 1'b1;
          if (dmem_ready) begin
            if (is_store) complete = 1'b1;
            else          state_next = WAIT_R;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        req_raw = 1'b1;
        if (dmem_ready) begin
          if (is_store) begin
            complete   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (dmem_rvalid) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Write-back value: link address for jumps, load data for loads, else ALU result.
  always_comb begin
    wb_sel = ex_mem_alu_result;
    if (ex_mem_jal || ex_mem_jalr) wb_sel = ex_mem_link_address_reg;
    else if (ex_mem_memtoreg)      wb_sel = dmem_rdata;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // MEM/WB register: results on completion, a bubble on every stalled edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wb_regwrite <= 1'b0;
      mem_wb_reg_dest <= 5'd0;
      mem_wb_wb_data  <= 32'd0;
    end else if (complete) begin
      mem_wb_regwrite <= ex_mem_regwrite & ~fault;
      mem_wb_reg_dest <= ex_mem_reg_dest;
      mem_wb_wb_data  <= wb_sel;
    end else begin
      mem_wb_regwrite <= 1'b0;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Single-cycle alignment fault pulse; the faulting access completes at once.
  always_ff @(posedge clk) begin
    if (reset) mem_misaligned <= 1'b0;
    else       mem_misaligned <= fault;
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed, table-driven bench for mem_access_stage.
// Optional feature macro: MEM_ALIGN_CHECK_EN (selects the alignment sequence).
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg;
  logic        ex_mem_regwrite, ex_mem_jal, ex_mem_jalr;
  logic [31:0] ex_mem_alu_result, ex_mem_data_read2, ex_mem_link_address_reg;
  logic [4:0]  ex_mem_reg_dest;
  logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, mem_wb_regwrite;
  logic [4:0]  mem_wb_reg_dest;
  logic [31:0] mem_wb_wb_data;
  logic [1:0]  state_dbg;
`ifdef MEM_ALIGN_CHECK_EN
  logic        mem_misaligned;
`endif

  int checks   = 0;
  int failures = 0;

  // ctrl = {memread, memwrite, memtoreg, regwrite, jal, jalr}
  // exp_bus = {dmem_req, dmem_we, mem_stall} before the edge
  typedef struct {
    logic [5:0]  ctrl;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] link;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [2:0]  exp_bus;
    logic [31:0] exp_addr;
    logic        exp_rw;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t tbl[12];
  vec_t v;

  mem_access_stage dut (
    .clk                     (clk),
    .reset                   (reset),
    .ex_mem_memread          (ex_mem_memread),
    .ex_mem_memwrite         (ex_mem_memwrite),
    .ex_mem_memtoreg         (ex_mem_memtoreg),
    .ex_mem_regwrite         (ex_mem_regwrite),
    .ex_mem_jal              (ex_mem_jal),
    .ex_mem_jalr             (ex_mem_jalr),
    .ex_mem_alu_result       (ex_mem_alu_result),
    .ex_mem_data_read2       (ex_mem_data_read2),
    .ex_mem_reg_dest         (ex_mem_reg_dest),
    .ex_mem_link_address_reg (ex_mem_link_address_reg),
    .dmem_req                (dmem_req),
    .dmem_we                 (dmem_we),
    .dmem_addr               (dmem_addr),
    .dmem_wdata              (dmem_wdata),
    .dmem_ready              (dmem_ready),
    .dmem_rvalid             (dmem_rvalid),
    .dmem_rdata              (dmem_rdata),
    .mem_stall               (mem_stall),
    .mem_wb_regwrite         (mem_wb_regwrite),
    .mem_wb_reg_dest         (mem_wb_reg_dest),
    .mem_wb_wb_data          (mem_wb_wb_data),
`ifdef MEM_ALIGN_CHECK_EN
    .mem_misaligned          (mem_misaligned),
`endif
    .state_dbg               (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t d);
    {ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg,
     ex_mem_regwrite, ex_mem_jal, ex_mem_jalr} = d.ctrl;
    ex_mem_alu_result       = d.alu;
    ex_mem_data_read2       = d.wdata;
    ex_mem_reg_dest         = d.rd;
    ex_mem_link_address_reg = d.link;
    dmem_ready              = d.ready;
    dmem_rvalid             = d.rvalid;
    dmem_rdata              = d.rdata;
  endtask

  // Called just after a rising edge: drive, check combinational outputs mid-cycle,
  // then check the MEM/WB register just after the next rising edge.
  task automatic apply_vec(input string name, input vec_t d);
    drive(d);
    #4;
    chk({name, ".req"},   {31'd0, dmem_req},  {31'd0, d.exp_bus[2]});
    chk({name, ".stall"}, {31'd0, mem_stall}, {31'd0, d.exp_bus[0]});
    if (d.exp_bus[2]) begin
      chk({name, ".we"},   {31'd0, dmem_we}, {31'd0, d.exp_bus[1]});
      chk({name, ".addr"}, dmem_addr, d.exp_addr);
      if (d.exp_bus[1]) chk({name, ".wdata"}, dmem_wdata, d.wdata);
    end
    @(posedge clk);
    #1;
    chk({name, ".regwrite"}, {31'd0, mem_wb_regwrite}, {31'd0, d.exp_rw});
    if (d.exp_rw) begin
      chk({name, ".rd"}, {27'd0, mem_wb_reg_dest}, {27'd0, d.exp_rd});
      chk({name, ".wb"}, mem_wb_wb_data, d.exp_wb);
    end
  endtask

  initial begin
    int stall_cycles;

    tbl[0]  = '{6'b000100, 32'h10,    32'h0,        5'd5, 32'h0,  1'b0, 1'b0, 32'h0,
                3'b000, 32'h0,   1'b1, 5'd5, 32'h10};
    tbl[1]  = '{6'b010000, 32'h100,   32'hDEADBEEF, 5'd0, 32'h0,  1'b1, 1'b0, 32'h0,
                3'b110, 32'h100, 1'b0, 5'd0, 32'h0};
    tbl[2]  = '{6'b000110, 32'h999,   32'h0,        5'd1, 32'h44, 1'b0, 1'b0, 32'h0,
                3'b000, 32'h0,   1'b1, 5'd1, 32'h44};
    tbl[3]  = '{6'b000101, 32'h1234,  32'h0,        5'd2, 32'h88, 1'b0, 1'b0, 32'h0,
                3'b000, 32'h0,   1'b1, 5'd2, 32'h88};
    tbl[4]  = '{6'b101100, 32'h300,   32'h0,        5'd9, 32'h0,  1'b1, 1'b0, 32'h0,
                3'b101, 32'h300, 1'b0, 5'd0, 32'h0};
    tbl[5]  = '{6'b101100, 32'h300,   32'h0,        5'd9, 32'h0,  1'b0, 1'b1, 32'hCAFE0001,
                3'b000, 32'h0,   1'b1, 5'd9, 32'hCAFE0001};
    tbl[6]  = '{6'b010000, 32'h104,   32'h55,       5'd0, 32'h0,  1'b0, 1'b0, 32'h0,
                3'b111, 32'h104, 1'b0, 5'd0, 32'h0};
    tbl[7]  = '{6'b010000, 32'h104,   32'h55,       5'd0, 32'h0,  1'b1, 1'b0, 32'h0,
                3'b110, 32'h104, 1'b0, 5'd0, 32'h0};
    tbl[8]  = '{6'b110000, 32'h108,   32'hAA,       5'd0, 32'h0,  1'b1, 1'b0, 32'h0,
                3'b110, 32'h108, 1'b0, 5'd0, 32'h0};
    tbl[9]  = '{6'b000100, 32'h77,    32'h0,        5'd3, 32'h0,  1'b1, 1'b1, 32'hBAD0BAD0,
                3'b000, 32'h0,   1'b1, 5'd3, 32'h77};
    tbl[10] = '{6'b000000, 32'h55,    32'h0,        5'd4, 32'h0,  1'b0, 1'b0, 32'h0,
                3'b000, 32'h0,   1'b0, 5'd0, 32'h0};
    tbl[11] = '{6'b000110, 32'h0,     32'h0,        5'd31, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0,
                3'b000, 32'h0,   1'b1, 5'd31, 32'hFFFFFFFC};

    // Reset, with a load pending so the request gating is exercised.
    reset = 1'b1;
    v = tbl[4];
    drive(v);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req",      {31'd0, dmem_req},        32'd0);
    chk("rst.regwrite", {31'd0, mem_wb_regwrite}, 32'd0);
    chk("rst.rd",       {27'd0, mem_wb_reg_dest}, 32'd0);
    chk("rst.wb",       mem_wb_wb_data,           32'd0);
    chk("rst.state",    {30'd0, state_dbg},       32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("rst.misaligned", {31'd0, mem_misaligned}, 32'd0);
`endif
    reset = 1'b0;
    v = tbl[10];
    drive(v);
    @(posedge clk);
    #1;

    // Table-driven single and two-cycle operations.
    for (int i = 0; i < 12; i++) apply_vec($sformatf("vec%0d", i), tbl[i]);

    // Load 0x200: ready low two cycles, accepted on the third, rvalid three later.
    stall_cycles = 0;
    v = '{6'b101100, 32'h200, 32'h0, 5'd7, 32'h0, 1'b0, 1'b0, 32'h0,
          3'b101, 32'h200, 1'b0, 5'd0, 32'h0};
    for (int c = 0; c < 6; c++) begin
      v.ready   = (c == 2);
      v.rvalid  = (c == 5);
      v.rdata   = (c == 5) ? 32'h12345678 : 32'hFFFF0000;
      v.exp_bus = (c < 3) ? 3'b101 : ((c < 5) ? 3'b001 : 3'b000);
      v.exp_rw  = (c == 5);
      v.exp_rd  = 5'd7;
      v.exp_wb  = 32'h12345678;
      drive(v);
      #2;
      if (mem_stall) stall_cycles++;
      #2;
      @(posedge clk);
      #1;
      chk($sformatf("ld.c%0d.regwrite", c), {31'd0, mem_wb_regwrite}, {31'd0, v.exp_rw});
    end
    chk("ld.stall_cycles", stall_cycles, 32'd5);
    chk("ld.rd", {27'd0, mem_wb_reg_dest}, 32'd7);
    chk("ld.wb", mem_wb_wb_data, 32'h12345678);

    // Reset while in WAIT_R, then a late rvalid after release.
    v = '{6'b101100, 32'h400, 32'h0, 5'd8, 32'h0, 1'b1, 1'b0, 32'h0,
          3'b101, 32'h400, 1'b0, 5'd0, 32'h0};
    apply_vec("rmid.issue", v);
    chk("rmid.state_wait", {30'd0, state_dbg}, 32'd2);
    v.ready = 1'b0;
    drive(v);
    reset = 1'b1;
    #4;
    chk("rmid.req_in_reset", {31'd0, dmem_req}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rmid.state", {30'd0, state_dbg}, 32'd0);
    v = '{6'b000000, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1, 32'hDEAD0000,
          3'b000, 32'h0, 1'b0, 5'd0, 32'h0};
    apply_vec("rmid.late_rvalid", v);
    chk("rmid.state_after", {30'd0, state_dbg}, 32'd0);
    chk("rmid.wb_clear", mem_wb_wb_data, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned load: no request, no stall, one-cycle fault pulse, bubble.
    v = '{6'b101100, 32'h202, 32'h0, 5'd6, 32'h0, 1'b1, 1'b0, 32'h0,
          3'b000, 32'h0, 1'b0, 5'd0, 32'h0};
    apply_vec("mis.ld", v);
    chk("mis.pulse", {31'd0, mem_misaligned}, 32'd1);
    v = tbl[10];
    apply_vec("mis.after", v);
    chk("mis.pulse_end", {31'd0, mem_misaligned}, 32'd0);
`else
    // Without the check, the low address bits are cleared and the load proceeds.
    v = '{6'b101100, 32'h203, 32'h0, 5'd6, 32'h0, 1'b1, 1'b0, 32'h0,
          3'b101, 32'h200, 1'b0, 5'd0, 32'h0};
    apply_vec("mis.ld_issue", v);
    v = '{6'b101100, 32'h203, 32'h0, 5'd6, 32'h0, 1'b0, 1'b1, 32'hA5A5A5A5,
          3'b000, 32'h0, 1'b1, 5'd6, 32'hA5A5A5A5};
    apply_vec("mis.ld_data", v);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage RV32I pipeline, sitting between the EX/MEM pipeline register and the register-file write-back. It consumes the EX/MEM control and data outputs and performs word loads and stores on the data-memory bus using a request/ready/rvalid handshake. It stalls the pipeline while an access is outstanding and registers the MEM/WB results, including write-back data selection between ALU result, load data and link address.

## Interface
- No parameters; data width fixed at 32, register index width fixed at 5.
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ex_mem_memread / ex_mem_memwrite / ex_mem_memtoreg / ex_mem_regwrite / ex_mem_jal / ex_mem_jalr  in  1 each  EX/MEM control bits
- ex_mem_alu_result  in  32  effective address or ALU result
- ex_mem_data_read2  in  32  store data
- ex_mem_reg_dest  in  5  destination register
- ex_mem_link_address_reg  in  32  PC+4 for JAL/JALR
- dmem_req  out  1  bus request valid
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  byte address
- dmem_wdata  out  32  store data
- dmem_ready  in  1  bus accepts request this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data
- mem_stall  out  1  freeze IF/ID/EX and EX/MEM this cycle
- mem_wb_regwrite  out  1  write-back enable
- mem_wb_reg_dest  out  5  write-back register
- mem_wb_wb_data  out  32  write-back value
- mem_misaligned  out  1  alignment fault pulse (only with MEM_ALIGN_CHECK_EN)

## Operation
- access = ex_mem_memread | ex_mem_memwrite; memread and memwrite both high is illegal, treated as store.
- FSM states: IDLE, REQ (request issued, not yet accepted), WAIT_R (load accepted, awaiting rvalid).
- dmem_req = (IDLE & access) | REQ; dmem_we = ex_mem_memwrite; dmem_addr = ex_mem_alu_result; dmem_wdata = ex_mem_data_read2 (combinational from EX/MEM).
- IDLE: no access → instruction completes. Access with ready=1: store completes; load → WAIT_R. Access with ready=0 → REQ.
- REQ: ready=1: store completes → IDLE; load → WAIT_R. ready=0: stay.
- WAIT_R: rvalid=1 → load completes, data = dmem_rdata → IDLE. Otherwise stay.
- mem_stall = 1 in every cycle the current EX/MEM instruction does not complete; 0 in its completion cycle.
- Upstream holds EX/MEM stable while mem_stall=1.
- Write-back select: jal|jalr → link address; else memtoreg → load data; else alu_result.
- rvalid outside WAIT_R is ignored; ready outside a requested cycle is ignored.

## Timing
- Reset values: state IDLE, mem_wb_regwrite 0, mem_wb_reg_dest 0, mem_wb_wb_data 0, mem_misaligned 0; dmem_req 0 while reset high.
- On completion edge: mem_wb_* <= selected values, mem_wb_regwrite <= ex_mem_regwrite.
- On stalled edge: mem_wb_regwrite <= 0 (bubble); reg_dest/wb_data don't care but held.
- Latency: non-memory op and store with ready=1 in first cycle: 0 stall cycles. Load: minimum 1 stall cycle (ready same cycle, rvalid next cycle).
- Rvalid coinciding with acceptance cycle is not supported; earliest rvalid is cycle after acceptance.
- Reset mid-access: FSM returns to IDLE, request dropped, no write-back issued; late rvalid ignored.

## Configuration
- MEM_ALIGN_CHECK_EN defined: access with alu_result[1:0] != 0 issues no request, does not stall, completes in one cycle with mem_wb_regwrite <= 0 and mem_misaligned <= 1 for exactly one cycle; mem_misaligned port present.
- Undefined: no check; dmem_addr[1:0] driven 0; mem_misaligned port absent.

## Test plan
- ADD result 0x0000_0010, rd=5, regwrite=1 → no stall, next cycle mem_wb_wb_data=0x10, reg_dest=5, regwrite=1.
- Store 0xDEAD_BEEF to 0x100, ready=1 immediately → dmem_req/we=1 one cycle, mem_stall=0, mem_wb_regwrite=0.
- Load 0x200, ready low 2 cycles then high, rvalid 3 cycles later with 0x1234_5678, rd=7 → mem_stall high 5 cycles, bubbles written, then wb_data=0x1234_5678, rd=7, regwrite=1.
- JAL with link 0x0000_0044, rd=1 → wb_data=0x44 regardless of alu_result.
- Reset asserted in WAIT_R, rvalid arrives after reset released → state IDLE, mem_wb_regwrite stays 0, no stall.
- With MEM_ALIGN_CHECK_EN: load from 0x202 → dmem_req never asserted, mem_misaligned one-cycle pulse, mem_wb_regwrite=0.
